// File: rtl/bwt_pkg.sv
// Shared BWT/MTF package: character width, default block length, MTF FSM states.
package bwt_pkg;
  localparam int CHAR_W = 8;
  localparam int STRING_LEN = 64;

  typedef logic [CHAR_W-1:0] char_t;

  typedef enum logic {
    IDLE,
    RUN
  } mtf_state_t;
endpackage

// File: rtl/bwt_mtf_encoder_if.sv
// Block handshake and index stream of the MTF encoder.
// zero_count exists only when BWT_MTF_ZSTAT_EN is defined.
interface bwt_mtf_encoder_if #(
  parameter int STRING_LEN = bwt_pkg::STRING_LEN,
  parameter int CHAR_W = bwt_pkg::CHAR_W
);
  localparam int ZC_W = $clog2(STRING_LEN + 1);

  logic start;
  logic [CHAR_W-1:0] in_char;
  logic in_valid;
  logic [CHAR_W-1:0] out_index;
  logic out_valid;
  logic out_last;
  logic busy;
  logic error;
`ifdef BWT_MTF_ZSTAT_EN
  logic [ZC_W-1:0] zero_count;
`endif

  modport master (
    output start, in_char, in_valid,
`ifdef BWT_MTF_ZSTAT_EN
    input zero_count,
`endif
    input out_index, out_valid, out_last, busy, error
  );

  modport slave (
    input start, in_char, in_valid,
`ifdef BWT_MTF_ZSTAT_EN
    output zero_count,
`endif
    output out_index, out_valid, out_last, busy, error
  );
endinterface

// File: rtl/mtf_search.sv
// Combinational recency-table lookup: lowest position holding key.
module mtf_search #(
  parameter int CHAR_W = 8
) (
  input  logic [(1<<CHAR_W)-1:0][CHAR_W-1:0] tbl,
  input  logic [CHAR_W-1:0] key,
  output logic [CHAR_W-1:0] idx
);
  localparam int DEPTH = 1 << CHAR_W;

  logic [DEPTH-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++)
      hit[i] = (tbl[i] == key);
  end

  // Scan downward so the lowest hit wins.
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (hit[i]) idx = CHAR_W'(i);
  end
endmodule

// File: rtl/bwt_mtf_encoder.sv
// Move-to-front encoder for BWT blocks; table resets to identity per block.
// Optional zero-index statistic enabled by BWT_MTF_ZSTAT_EN.
module bwt_mtf_encoder #(
  parameter int STRING_LEN = bwt_pkg::STRING_LEN,
  parameter int CHAR_W = bwt_pkg::CHAR_W
) (
  input logic clk,
  input logic rst,
  bwt_mtf_encoder_if.slave bus
);
  import bwt_pkg::*;

  localparam int DEPTH = 1 << CHAR_W;
  localparam int CNT_W = $clog2(STRING_LEN);

  mtf_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [DEPTH-1:0][CHAR_W-1:0] tbl;
  logic [CHAR_W-1:0] idx;
  logic last;

  mtf_search #(.CHAR_W(CHAR_W)) u_search (
    .tbl(tbl),
    .key(bus.in_char),
    .idx(idx)
  );

  assign last = (cnt == CNT_W'(STRING_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= CHAR_W'(i);
      bus.out_index <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.busy <= 1'b0;
      bus.error <= 1'b0;
`ifdef BWT_MTF_ZSTAT_EN
      bus.zero_count <= '0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) bus.error <= 1'b1;
          if (bus.start) begin
            for (int i = 0; i < DEPTH; i++)
              tbl[i] <= CHAR_W'(i);
            cnt <= '0;
            state <= RUN;
            bus.busy <= 1'b1;
`ifdef BWT_MTF_ZSTAT_EN
            bus.zero_count <= '0;
`endif
          end
        end
        RUN: begin
          if (bus.start) bus.error <= 1'b1;
          if (bus.in_valid) begin
            bus.out_index <= idx;
            bus.out_valid <= 1'b1;
            // Entries 0..idx-1 slide up one slot; the hit goes to the front.
            tbl[0] <= bus.in_char;
            for (int i = 1; i < DEPTH; i++)
              if (CHAR_W'(i) <= idx) tbl[i] <= tbl[i-1];
`ifdef BWT_MTF_ZSTAT_EN
            if (idx == '0) bus.zero_count <= bus.zero_count + 1'b1;
`endif
            if (last) begin
              bus.out_last <= 1'b1;
              bus.busy <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bwt_mtf_encoder.sv
// Directed bench for bwt_mtf_encoder with a small MTF reference for the gapped block.
module tb_bwt_mtf_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  bwt_mtf_encoder_if bus ();

  bwt_mtf_encoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mt [256];
  logic [7:0] exp_idx;
  logic [7:0] pat [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] c);
    bus.in_char = c;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mt[i] = 8'(i);
  endtask

  task automatic model_step(input logic [7:0] c, output logic [7:0] r);
    int p;
    p = 0;
    for (int i = 255; i >= 0; i--) if (mt[i] == c) p = i;
    r = 8'(p);
    for (int i = p; i > 0; i--) mt[i] = mt[i-1];
    mt[0] = c;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_char = '0;
    bus.in_valid = 1'b0;
    pat = '{8'h6e, 8'h6e, 8'h62, 8'h24, 8'h61, 8'h61, 8'h61, 8'h62,
            8'h6e, 8'h61, 8'h61, 8'h62, 8'h6e, 8'h24, 8'h61, 8'h6e};
    do_reset();

    chk("rst_out_index", 32'(bus.out_index), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_error", 32'(bus.error), 0);

    // single character
    pulse_start();
    chk("single_busy", 32'(bus.busy), 1);
    send(8'h61);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_index", 32'(bus.out_index), 32'h61);
    step();
    chk("single_valid_drop", 32'(bus.out_valid), 0);
    do_reset();

    // back-to-back "aab" then "a"
    pulse_start();
    send(8'h61);
    chk("b2b_0", 32'(bus.out_index), 32'h61);
    send(8'h61);
    chk("b2b_1", 32'(bus.out_index), 32'h00);
    chk("b2b_1_valid", 32'(bus.out_valid), 1);
    send(8'h62);
    chk("b2b_2", 32'(bus.out_index), 32'h62);
    send(8'h61);
    chk("b2b_3", 32'(bus.out_index), 32'h01);
    chk("b2b_3_last", 32'(bus.out_last), 0);
    do_reset();

    // full block: 63 x 'a' then '$'
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      bus.in_char = (i == 63) ? 8'h24 : 8'h61;
      bus.in_valid = 1'b1;
      step();
      chk("full_valid", 32'(bus.out_valid), 1);
      chk("full_index", 32'(bus.out_index),
          (i == 0) ? 32'h61 : (i == 63) ? 32'h25 : 32'h00);
      chk("full_last", 32'(bus.out_last), (i == 63) ? 1 : 0);
    end
    bus.in_valid = 1'b0;
    chk("full_busy_fall", 32'(bus.busy), 0);
`ifdef BWT_MTF_ZSTAT_EN
    chk("full_zero_count", 32'(bus.zero_count), 62);
`endif
    // new start accepted while out_last is high
    pulse_start();
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_last_drop", 32'(bus.out_last), 0);
    chk("restart_error", 32'(bus.error), 0);
    do_reset();

    // in_valid while idle
    send(8'h41);
    chk("idle_valid_dropped", 32'(bus.out_valid), 0);
    chk("idle_error", 32'(bus.error), 1);
    step();
    step();
    chk("idle_error_sticky", 32'(bus.error), 1);
    do_reset();
    chk("error_cleared", 32'(bus.error), 0);

    // gapped block, with a stray start inside it
    model_reset();
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      model_step(pat[i % 16], exp_idx);
      send(pat[i % 16]);
      chk("gap_valid", 32'(bus.out_valid), 1);
      chk("gap_index", 32'(bus.out_index), 32'(exp_idx));
      chk("gap_last", 32'(bus.out_last), (i == 63) ? 1 : 0);
      if (i == 20) begin
        pulse_start();
        chk("run_start_busy", 32'(bus.busy), 1);
        chk("run_start_error", 32'(bus.error), 1);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step();
        chk("gap_idle", 32'(bus.out_valid), 0);
      end
    end
    chk("gap_busy_end", 32'(bus.busy), 0);
    chk("gap_error_held", 32'(bus.error), 1);
    do_reset();

    // reset mid-block
    pulse_start();
    for (int i = 0; i < 10; i++) send(8'h62 + 8'(i));
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_last", 32'(bus.out_last), 0);
    step();
    rst = 1'b0;
    pulse_start();
    send(8'h61);
    chk("midrst_index", 32'(bus.out_index), 32'h61);
    chk("midrst_valid", 32'(bus.out_valid), 1);
    chk("midrst_no_last", 32'(bus.out_last), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
